// File: rtl/slc3_mem_pkg.sv
// Shared types and defaults for the SLC-3 SRAM arbiter: FSM state encoding,
// grant encoding and the default timing/width parameters.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int WAIT_STATES_DEFAULT = 2;
    localparam int AW_DEFAULT          = 16;
    localparam int DW_DEFAULT          = 16;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_LDR = 1'b1;

endpackage

// File: rtl/slc3_mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: req[0] is the CPU, req[1] the loader; on a tie
// the requester that did not win last time is chosen.
module rr_arb2
    import slc3_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = last;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = GRANT_LDR;
        end else if (req[0]) begin
            grant = GRANT_CPU;
        end
    end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Arbitrates CPU and loader accesses onto one asynchronous SRAM port using an
// IDLE/SETUP/ACCESS/DONE sequence with registered active-low strobes.
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEFAULT,
    parameter int AW          = AW_DEFAULT,
    parameter int DW          = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          CE_n,
    output logic          OE_n,
    output logic          WE_n,
    output logic          UB_n,
    output logic          LB_n,
    output logic          busy
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          busy_q, busy_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ldr_ack_q, ldr_ack_d;
    logic          arb_grant;

    rr_arb2 u_rr_arb2 (
        .req   ({ldr_req, cpu_req}),
        .last  (grant_q),
        .grant (arb_grant)
    );

    // grant_q doubles as the last-grant memory for the round-robin tie break.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    state_d = SETUP;
                    grant_d = arb_grant;
                    we_d    = (arb_grant == GRANT_LDR) ? ldr_we    : cpu_we;
                    addr_d  = (arb_grant == GRANT_LDR) ? ldr_addr  : cpu_addr;
                    wdata_d = (arb_grant == GRANT_LDR) ? ldr_wdata : cpu_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (grant_q == GRANT_LDR) begin
                            ldr_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are glitch-free flops.
        ce_n_d    = !((state_d == SETUP) || (state_d == ACCESS));
        oe_n_d    = !((state_d == ACCESS) && !we_d);
        we_n_d    = !((state_d == ACCESS) && we_d);
        busy_d    = (state_d != IDLE);
        cpu_ack_d = (state_d == DONE) && (grant_d == GRANT_CPU);
        ldr_ack_d = (state_d == DONE) && (grant_d == GRANT_LDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            grant_q     <= GRANT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            busy_q      <= busy_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign CE_n      = ce_n_q;
    assign UB_n      = ce_n_q;
    assign LB_n      = ce_n_q;
    assign OE_n      = oe_n_q;
    assign WE_n      = we_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed self-checking bench for slc3_mem_arbiter; extra instances cover the
// WAIT_STATES=1 and WAIT_STATES=15 timing corners.
module tb_slc3_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, mem_rdata;
    logic        cpu_ack, ldr_ack;
    logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
    logic        CE_n, OE_n, WE_n, UB_n, LB_n, busy;

    logic        noReq;
    logic        w1CpuReq, w15CpuReq;
    logic        w1CpuAck, w1LdrAck, w15CpuAck, w15LdrAck;
    logic [15:0] w1CpuRdata, w1LdrRdata, w1MemAddr, w1MemWdata;
    logic [15:0] w15CpuRdata, w15LdrRdata, w15MemAddr, w15MemWdata;
    logic        w1Ce, w1Oe, w1We, w1Ub, w1Lb, w1Busy;
    logic        w15Ce, w15Oe, w15We, w15Ub, w15Lb, w15Busy;

    int testCount = 0;
    int failCount = 0;

    slc3_mem_arbiter #(.WAIT_STATES(2), .AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .UB_n(UB_n), .LB_n(LB_n), .busy(busy)
    );

    slc3_mem_arbiter #(.WAIT_STATES(1), .AW(16), .DW(16)) uWs1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(w1CpuReq), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(w1CpuAck), .cpu_rdata(w1CpuRdata),
        .ldr_req(noReq), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(w1LdrAck), .ldr_rdata(w1LdrRdata),
        .mem_addr(w1MemAddr), .mem_wdata(w1MemWdata), .mem_rdata(mem_rdata),
        .CE_n(w1Ce), .OE_n(w1Oe), .WE_n(w1We), .UB_n(w1Ub), .LB_n(w1Lb), .busy(w1Busy)
    );

    slc3_mem_arbiter #(.WAIT_STATES(15), .AW(16), .DW(16)) uWs15 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(w15CpuReq), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(w15CpuAck), .cpu_rdata(w15CpuRdata),
        .ldr_req(noReq), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(w15LdrAck), .ldr_rdata(w15LdrRdata),
        .mem_addr(w15MemAddr), .mem_wdata(w15MemWdata), .mem_rdata(mem_rdata),
        .CE_n(w15Ce), .OE_n(w15Oe), .WE_n(w15We), .UB_n(w15Ub), .LB_n(w15Lb), .busy(w15Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction on the main instance starting at a negedge; counts
    // edges to the ack, strobe-low cycles, and ack pulses for each requester.
    task automatic applyStimulus(input bit isLdr, input bit we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] rd,
                                 output int lat, output int oeLow, output int weLow,
                                 output int acks, output int otherAcks);
        bit done;
        done = 0; lat = 0; oeLow = 0; weLow = 0; acks = 0; otherAcks = 0;
        mem_rdata = rd;
        if (isLdr) begin
            ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (!OE_n) oeLow++;
            if (!WE_n) weLow++;
            if (isLdr ? cpu_ack : ldr_ack) otherAcks++;
            if (isLdr ? ldr_ack : cpu_ack) begin
                acks++;
                done = 1;
            end
        end
        if (isLdr) ldr_req = 0; else cpu_req = 0;
        @(posedge clk); @(negedge clk);
        if (isLdr ? ldr_ack : cpu_ack) acks++;
        if (isLdr ? cpu_ack : ldr_ack) otherAcks++;
    endtask

    task automatic measureExtra(input bit big, output int lat, output int oeLow);
        bit done;
        done = 0; lat = 0; oeLow = 0;
        if (big) w15CpuReq = 1; else w1CpuReq = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (!(big ? w15Oe : w1Oe)) oeLow++;
            if (big ? w15CpuAck : w1CpuAck) done = 1;
        end
        if (big) w15CpuReq = 0; else w1CpuReq = 0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        int lat, oeLow, weLow, acks, otherAcks, addrBad, ackCount;
        int order[$];
        bit sawAccess;

        rst_n = 0; noReq = 0; w1CpuReq = 0; w15CpuReq = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; mem_rdata = 0;
        @(negedge clk); @(negedge clk);

        checkOutput("rst_ce_n", CE_n, 1);
        checkOutput("rst_oe_n", OE_n, 1);
        checkOutput("rst_we_n", WE_n, 1);
        checkOutput("rst_ub_lb", {UB_n, LB_n}, 2'b11);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_acks", {cpu_ack, ldr_ack}, 2'b00);
        checkOutput("rst_cpu_rdata", cpu_rdata, 16'h0000);
        checkOutput("rst_ldr_rdata", ldr_rdata, 16'h0000);
        checkOutput("rst_mem_addr", mem_addr, 16'h0000);
        checkOutput("rst_mem_wdata", mem_wdata, 16'h0000);
        rst_n = 1;
        @(negedge clk);

        $display("[TB] CPU read 0x0030");
        applyStimulus(0, 0, 16'h0030, 16'h0000, 16'h1234, lat, oeLow, weLow, acks, otherAcks);
        checkOutput("cpu_rd_latency", lat, 4);
        checkOutput("cpu_rd_oe_cycles", oeLow, 2);
        checkOutput("cpu_rd_we_cycles", weLow, 0);
        checkOutput("cpu_rd_ack_pulses", acks, 1);
        checkOutput("cpu_rd_ldr_ack", otherAcks, 0);
        checkOutput("cpu_rd_rdata", cpu_rdata, 16'h1234);
        checkOutput("cpu_rd_ldr_rdata", ldr_rdata, 16'h0000);
        checkOutput("cpu_rd_mem_addr", mem_addr, 16'h0030);
        checkOutput("cpu_rd_busy_after", busy, 0);

        $display("[TB] loader write 0x0000 <= 0xBEEF");
        applyStimulus(1, 1, 16'h0000, 16'hBEEF, 16'h7777, lat, oeLow, weLow, acks, otherAcks);
        checkOutput("ldr_wr_latency", lat, 4);
        checkOutput("ldr_wr_we_cycles", weLow, 2);
        checkOutput("ldr_wr_oe_cycles", oeLow, 0);
        checkOutput("ldr_wr_ack_pulses", acks, 1);
        checkOutput("ldr_wr_cpu_ack", otherAcks, 0);
        checkOutput("ldr_wr_mem_addr", mem_addr, 16'h0000);
        checkOutput("ldr_wr_mem_wdata", mem_wdata, 16'hBEEF);
        checkOutput("ldr_wr_ldr_rdata", ldr_rdata, 16'h0000);
        checkOutput("ldr_wr_cpu_rdata", cpu_rdata, 16'h1234);

        $display("[TB] both requesting from reset");
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0200;
        for (int i = 0; i < 60 && order.size() < 4; i++) begin
            @(posedge clk); @(negedge clk);
            if (ldr_ack) order.push_back(1);
            if (cpu_ack) order.push_back(0);
        end
        cpu_req = 0; ldr_req = 0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checkOutput("rr_grant_count", order.size(), 4);
        while (order.size() < 4) order.push_back(9);
        checkOutput("rr_grant0_ldr", order[0], 1);
        checkOutput("rr_grant1_cpu", order[1], 0);
        checkOutput("rr_grant2_ldr", order[2], 1);
        checkOutput("rr_grant3_cpu", order[3], 0);

        $display("[TB] CPU address change during ACCESS");
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h0A0A;
        addrBad = 0; ackCount = 0; lat = 0; sawAccess = 0;
        for (int i = 0; i < 40 && ackCount == 0; i++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (mem_addr !== 16'h0010) addrBad++;
            if (!WE_n) begin
                sawAccess = 1;
                cpu_addr = 16'h0020;
                cpu_wdata = 16'h5555;
            end
            if (cpu_ack) ackCount++;
        end
        checkOutput("hold_access_seen", sawAccess, 1);
        checkOutput("hold_mem_addr_bad_cycles", addrBad, 0);
        checkOutput("hold_mem_wdata", mem_wdata, 16'h0A0A);
        checkOutput("hold_latency", lat, 4);
        cpu_req = 0;
        @(posedge clk); @(negedge clk);

        $display("[TB] reset during ACCESS");
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; mem_rdata = 16'hDEAD;
        sawAccess = 0;
        for (int i = 0; i < 40 && !sawAccess; i++) begin
            @(posedge clk); @(negedge clk);
            if (!OE_n) sawAccess = 1;
        end
        checkOutput("abort_reached_access", sawAccess, 1);
        rst_n = 0;
        #1;
        checkOutput("abort_strobes", {CE_n, OE_n, WE_n, UB_n, LB_n}, 5'b11111);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_cpu_rdata", cpu_rdata, 16'h0000);
        cpu_req = 0;
        @(negedge clk);
        rst_n = 1;
        ackCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            if (cpu_ack || ldr_ack) ackCount++;
        end
        checkOutput("abort_no_ack", ackCount, 0);
        applyStimulus(0, 0, 16'h0044, 16'h0000, 16'h5A5A, lat, oeLow, weLow, acks, otherAcks);
        checkOutput("post_abort_latency", lat, 4);
        checkOutput("post_abort_acks", acks, 1);
        checkOutput("post_abort_rdata", cpu_rdata, 16'h5A5A);

        $display("[TB] WAIT_STATES 1 and 15");
        cpu_we = 0; cpu_addr = 16'h0050; mem_rdata = 16'h0F0F;
        measureExtra(0, lat, oeLow);
        checkOutput("ws1_latency", lat, 3);
        checkOutput("ws1_oe_cycles", oeLow, 1);
        checkOutput("ws1_rdata", w1CpuRdata, 16'h0F0F);
        mem_rdata = 16'hC3C3;
        measureExtra(1, lat, oeLow);
        checkOutput("ws15_latency", lat, 17);
        checkOutput("ws15_oe_cycles", oeLow, 15);
        checkOutput("ws15_rdata", w15CpuRdata, 16'hC3C3);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/slc3_mem_arbiter.md
SLC3_MEM_ARBITER -- requirements
Module: slc3_mem_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 2, shall set the number of strobe-active ACCESS cycles per transaction (legal 1..15).
REQ-002 Parameter AW, default 16, shall set the address width.
REQ-003 Parameter DW, default 16, shall set the data width.
REQ-004 Clk  in  1  system clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 cpu_req / ldr_req  in  1 each  level request from CPU / memory loader; held until matching ack.
REQ-007 cpu_we / ldr_we  in  1 each  1 = write, 0 = read.
REQ-008 cpu_addr / ldr_addr  in  AW each  word address.
REQ-009 cpu_wdata / ldr_wdata  in  DW each  write data.
REQ-010 cpu_ack / ldr_ack  out  1 each  single-cycle completion pulse.
REQ-011 cpu_rdata / ldr_rdata  out  DW each  registered read data.
REQ-012 mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW  SRAM port.
REQ-013 CE_n, OE_n, WE_n, UB_n, LB_n  out  1 each  active-low SRAM strobes.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM shall have states IDLE, SETUP, ACCESS, DONE; IDLE->SETUP when any req high; SETUP->ACCESS after 1 cycle; ACCESS->DONE after WAIT_STATES cycles; DONE->IDLE after 1 cycle.
REQ-016 On IDLE->SETUP the block shall latch grant, we, addr and wdata of the winner; requester input changes afterwards shall be ignored until DONE.
REQ-017 With one request pending, that requester shall win; with both pending, the requester not granted last shall win (round-robin).
REQ-018 CE_n, UB_n, LB_n shall be 0 in SETUP and ACCESS, 1 otherwise; OE_n = 0 only in ACCESS for reads; WE_n = 0 only in ACCESS for writes.
REQ-019 mem_addr and mem_wdata shall present the latched values from SETUP through DONE.
REQ-020 For reads, mem_rdata shall be captured into the granted requester's rdata on the last ACCESS cycle; the other requester's rdata shall be unchanged.
REQ-021 The granted requester's ack shall be high exactly during DONE; latency = WAIT_STATES+2 cycles from the edge that samples req to the ack cycle.
REQ-022 rdata shall hold its value until the next read completes for the same requester.
REQ-023 A req still high in the IDLE cycle after DONE shall be treated as a new request.
REQ-024 The ACCESS wait counter shall be a 4-bit down-counter loaded with WAIT_STATES-1 on SETUP->ACCESS; it shall not wrap.
REQ-025 Write data shall not be driven when WE_n = 1 is irrelevant to the block; mem_wdata shall always be driven from the latch (no tristate).

Reset
REQ-026 When Reset = 0, asynchronously: state = IDLE; CE_n, OE_n, WE_n, UB_n, LB_n = 1; acks = 0; busy = 0; rdata = 0; mem_addr, mem_wdata = 0; last-grant = CPU (loader wins first tie).
REQ-027 A reset asserted mid-transaction shall abort it with no ack issued; after release the FSM shall restart from IDLE.

Structure
REQ-028 Package slc3_mem_pkg shall hold the state enum, the WAIT_STATES default, and AW/DW default constants.
REQ-029 Round-robin selection shall be a sub-module rr_arb2 (inputs req[1:0], last; output grant); all else in slc3_mem_arbiter.

Verification
REQ-030 CPU read 0x0030, WAIT_STATES=2, mem_rdata=0x1234 -> OE_n low 2 cycles, cpu_ack 4 cycles after sample, cpu_rdata=0x1234, ldr_rdata unchanged.
REQ-031 Loader write 0x0000 data 0xBEEF -> WE_n low 2 cycles, OE_n high throughout, mem_addr=0x0000, mem_wdata=0xBEEF, ldr_ack one pulse.
REQ-032 Both req high from reset, held -> grant order loader, CPU, loader, CPU; no back-to-back grant to one requester.
REQ-033 CPU changes cpu_addr 0x0010->0x0020 during ACCESS -> mem_addr stays 0x0010 until DONE.
REQ-034 Reset low during ACCESS -> all strobes 1 and busy 0 immediately (before next edge), no ack, next request completes normally.
REQ-035 WAIT_STATES=1 and 15 -> ACCESS lasts 1 and 15 cycles, ack latency 3 and 17.
